if_stream: RTL and testbench
============================

Name: if_stream

Overview:
- Instruction-fetch front end of the 5-stage valid/allowin pipeline. It is the producer end of the handshake that the writeback stage terminates.
- Generates the next PC (sequential or branch-redirected) and issues reads to a synchronous instruction SRAM.
- Holds fetched instructions in a one-entry buffer across ID stalls and delivers {pc, inst} to ID.
- Cancels the wrong-path instruction on a taken branch.

Parameters:
- RESET_PC, 32'h1c000000, address of the first instruction fetched after reset.

Ports:
- clk  in  1  clock, all state on posedge
- reset  in  1  asynchronous, active-high reset
- ID_allowin  in  1  ID stage can accept an instruction this cycle
- br_taken  in  1  taken-branch/jump redirect from ID (single-cycle pulse)
- br_target  in  32  redirect target, valid when br_taken=1
- inst_sram_en  out  1  SRAM read enable
- inst_sram_we  out  4  byte write enables, constant 4'b0
- inst_sram_addr  out  32  SRAM byte address
- inst_sram_wdata  out  32  constant 32'b0
- inst_sram_rdata  in  32  read data, valid the cycle after en=1
- IF_to_ID_valid  out  1  IF holds a deliverable instruction
- IF_pc_out  out  32  PC of the instruction in IF
- IF_inst_out  out  32  instruction word in IF

Behaviour:
- Reset (async, any time, including mid-stall):
  - IF_valid=0, IF_pc=RESET_PC-4, inst_buf_valid=0, inst_buf=0.
  - Outputs during reset: inst_sram_en=0, IF_to_ID_valid=0, IF_pc_out=RESET_PC-4, IF_inst_out=0.
- Next PC: nextpc = br_taken ? br_target : IF_pc+4. Modulo-2^32 add; 32'hfffffffc wraps to 0.
- IF_allowin = !IF_valid || ID_allowin || br_taken. A flushed instruction never waits on ID.
- IF_ready_go = 1 (SRAM always responds in 1 cycle).
- Request: inst_sram_en = !reset && IF_allowin; inst_sram_addr = nextpc.
- On posedge with IF_allowin=1: IF_valid<=1, IF_pc<=nextpc. First fetch after reset release is RESET_PC, issued in the first cycle with reset low.
- Instruction data:
  - Cycle after an issue, inst_sram_rdata belongs to IF_pc.
  - IF_inst_out = inst_buf_valid ? inst_buf : inst_sram_rdata.
  - If IF_valid && !ID_allowin && !inst_buf_valid && !br_taken: inst_buf<=inst_sram_rdata, inst_buf_valid<=1.
  - inst_buf_valid clears on any posedge with IF_allowin=1.
- Handoff: IF_to_ID_valid = IF_valid && !br_taken. ID latches on IF_to_ID_valid && ID_allowin.
- Taken branch, same cycle as br_taken:
  - The IF instruction is suppressed.
  - br_target is requested.
  - Buffer is discarded.
  - Next cycle IF_pc=br_target.
- br_taken with ID_allowin=0 still redirects; no pending state.
- Back-to-back br_taken in consecutive cycles: last target wins.
- Stall of N cycles: en=0 for N cycles, IF_pc/IF_inst_out held stable, exactly one instruction delivered.

Optional Feature:
- Macro: IF_ADEF_EN.
- Defined:
  - Adds output IF_adef (1 bit) = IF_valid && (IF_pc[1:0]!=0).
  - inst_sram_en is gated to 0 when nextpc[1:0]!=0.
  - IF_inst_out is forced to 32'h03400000 (NOP) while IF_adef=1.
  - The faulting instruction is still delivered once, with IF_adef=1.
- Undefined: no IF_adef port; PC alignment is unchecked.

Decomposition:
- Shared pipeline package:
  - RESET_PC default
  - NOP_INST = 32'h03400000
  - PC_WIDTH = 32
  - INST_WIDTH = 32
  - SRAM write-enable width = 4
- No sub-module needed; the +4 adder and muxes are inline. The instruction buffer is optionally a small inst_hold_buf (one-entry, valid+data).

Test Plan:
- Reset release, ID_allowin=1 -> addrs 1c000000, 1c000004, 1c000008 on consecutive cycles; IF_to_ID_valid=1 from cycle 2, pc/inst pairs match SRAM contents.
- ID_allowin=0 for 3 cycles while IF_pc=1c000008, inst 0x02800421 -> en=0, IF_inst_out stays 0x02800421 from buffer; one delivery when ID_allowin=1; next addr 1c00000c.
- br_taken=1, br_target=1c000100 while IF_pc=1c000010 -> IF_to_ID_valid=0 that cycle; addr=1c000100; next cycle IF_pc=1c000100, no delivery of 1c000010.
- br_taken during ID stall (ID_allowin=0, buffer full) -> buffer cleared, redirect same cycle; buffered inst never reaches ID.
- Reset asserted mid-stall with inst_buf_valid=1 -> outputs clear immediately without clock; after release, fetch restarts at 1c000000.
- With IF_ADEF_EN, br_target=1c000102 -> en=0, next cycle IF_adef=1, IF_inst_out=03400000, delivered once.

Source files
------------

// File: rtl/if_stream_pkg.sv
// Shared pipeline constants and the IF->ID payload type for the fetch front end.
package if_stream_pkg;

  localparam int unsigned PC_WIDTH      = 32;
  localparam int unsigned INST_WIDTH    = 32;
  localparam int unsigned SRAM_WE_WIDTH = 4;

  localparam logic [PC_WIDTH-1:0]   RESET_PC_DEF = 32'h1c000000;
  localparam logic [INST_WIDTH-1:0] NOP_INST     = 32'h03400000;

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [INST_WIDTH-1:0] inst;
  } if_id_bus_t;

  function automatic logic pc_misaligned(input logic [PC_WIDTH-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_stream.sv
// Instruction-fetch stage: next-PC generation, SRAM request, one-entry hold buffer.
// Optional macro IF_ADEF_EN adds the IF_adef misaligned-fetch flag.
module if_stream
  import if_stream_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ID_allowin,
  input  logic                     br_taken,
  input  logic [PC_WIDTH-1:0]      br_target,
  output logic                     inst_sram_en,
  output logic [SRAM_WE_WIDTH-1:0] inst_sram_we,
  output logic [PC_WIDTH-1:0]      inst_sram_addr,
  output logic [INST_WIDTH-1:0]    inst_sram_wdata,
  input  logic [INST_WIDTH-1:0]    inst_sram_rdata,
`ifdef IF_ADEF_EN
  output logic                     IF_adef,
`endif
  output logic                     IF_to_ID_valid,
  output logic [PC_WIDTH-1:0]      IF_pc_out,
  output logic [INST_WIDTH-1:0]    IF_inst_out
);

  logic                  r_if_valid;
  logic [PC_WIDTH-1:0]   r_if_pc;
  logic                  r_buf_valid;
  logic [INST_WIDTH-1:0] r_buf;

  logic                  w_allowin;
  logic [PC_WIDTH-1:0]   w_nextpc;
  logic                  w_adef;
  if_id_bus_t            w_out;

  // A redirect always frees IF, so the wrong-path instruction never waits on ID.
  assign w_allowin = !r_if_valid || ID_allowin || br_taken;
  assign w_nextpc  = br_taken ? br_target : PC_WIDTH'(r_if_pc + PC_WIDTH'(4));

`ifdef IF_ADEF_EN
  assign w_adef       = r_if_valid && pc_misaligned(r_if_pc);
  assign IF_adef      = w_adef;
  assign inst_sram_en = !reset && w_allowin && !pc_misaligned(w_nextpc);
`else
  assign w_adef       = 1'b0;
  assign inst_sram_en = !reset && w_allowin;
`endif

  assign inst_sram_we    = '0;
  assign inst_sram_wdata = '0;
  assign inst_sram_addr  = w_nextpc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_if_valid  <= 1'b0;
      r_if_pc     <= PC_WIDTH'(RESET_PC - PC_WIDTH'(4));
      r_buf_valid <= 1'b0;
      r_buf       <= '0;
    end else if (w_allowin) begin
      r_if_valid  <= 1'b1;
      r_if_pc     <= w_nextpc;
      r_buf_valid <= 1'b0;
    end else if (r_if_valid && !r_buf_valid) begin
      // SRAM data is only valid for one cycle after the read; capture it on stall.
      r_buf_valid <= 1'b1;
      r_buf       <= inst_sram_rdata;
    end
  end

  always_comb begin
    w_out.pc   = r_if_pc;
    w_out.inst = r_buf_valid ? r_buf : inst_sram_rdata;
    if (w_adef) w_out.inst = NOP_INST;
    if (reset)  w_out.inst = '0;
  end

  assign IF_to_ID_valid = r_if_valid && !br_taken;
  assign IF_pc_out      = w_out.pc;
  assign IF_inst_out    = w_out.inst;

endmodule

// File: tb/tb_if_stream.sv
// Directed bench for if_stream with a 1-cycle synchronous instruction SRAM model.
// Define IF_ADEF_EN to also exercise the misaligned-fetch flag.
module tb_if_stream;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ID_allowin = 1'b1;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = '0;
  logic        IF_to_ID_valid;
  logic [31:0] IF_pc_out;
  logic [31:0] IF_inst_out;
`ifdef IF_ADEF_EN
  logic        IF_adef;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int dlv_008 = 0, dlv_010 = 0, dlv_100 = 0;

  if_stream dut (
    .clk            (clk),
    .reset          (reset),
    .ID_allowin     (ID_allowin),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_we   (inst_sram_we),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata),
`ifdef IF_ADEF_EN
    .IF_adef        (IF_adef),
`endif
    .IF_to_ID_valid (IF_to_ID_valid),
    .IF_pc_out      (IF_pc_out),
    .IF_inst_out    (IF_inst_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    if (a == 32'h1c000008) return 32'h02800421;
    return a ^ 32'h5a5a0000;
  endfunction

  always @(posedge clk) if (inst_sram_en) inst_sram_rdata <= inst_of(inst_sram_addr);

  // ID-side acceptance counter for the PCs whose delivery count matters.
  always @(posedge clk) begin
    if (IF_to_ID_valid && ID_allowin) begin
      if (IF_pc_out == 32'h1c000008) dlv_008++;
      if (IF_pc_out == 32'h1c000010) dlv_010++;
      if (IF_pc_out == 32'h1c000100) dlv_100++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    tick(); tick(); mid();
    chk("rst_en", 32'(inst_sram_en), 32'd0);
    chk("rst_valid", 32'(IF_to_ID_valid), 32'd0);
    chk("rst_pc", IF_pc_out, 32'h1bfffffc);
    chk("rst_inst", IF_inst_out, 32'h0);
    chk("we", 32'(inst_sram_we), 32'd0);
    chk("wdata", inst_sram_wdata, 32'h0);

    // Sequential fetch
    tick(); reset = 1'b0; mid();
    chk("a_en", 32'(inst_sram_en), 32'd1);
    chk("a_addr", inst_sram_addr, 32'h1c000000);
    chk("a_valid", 32'(IF_to_ID_valid), 32'd0);
    tick(); mid();
    chk("b_valid", 32'(IF_to_ID_valid), 32'd1);
    chk("b_pc", IF_pc_out, 32'h1c000000);
    chk("b_inst", IF_inst_out, 32'h465a0000);
    chk("b_addr", inst_sram_addr, 32'h1c000004);
    tick(); mid();
    chk("c_pc", IF_pc_out, 32'h1c000004);
    chk("c_inst", IF_inst_out, 32'h465a0004);
    chk("c_addr", inst_sram_addr, 32'h1c000008);

    // Three-cycle ID stall on 1c000008
    for (int i = 0; i < 3; i++) begin
      tick(); ID_allowin = 1'b0; mid();
      chk("stall_en", 32'(inst_sram_en), 32'd0);
      chk("stall_pc", IF_pc_out, 32'h1c000008);
      chk("stall_inst", IF_inst_out, 32'h02800421);
    end
    tick(); ID_allowin = 1'b1; mid();
    chk("rel_en", 32'(inst_sram_en), 32'd1);
    chk("rel_addr", inst_sram_addr, 32'h1c00000c);
    chk("rel_inst", IF_inst_out, 32'h02800421);
    tick(); mid();
    chk("dlv_008", 32'(dlv_008), 32'd1);
    chk("h_pc", IF_pc_out, 32'h1c00000c);
    chk("h_inst", IF_inst_out, 32'h465a000c);

    // Taken branch from 1c000010
    tick(); br_taken = 1'b1; br_target = 32'h1c000100; mid();
    chk("br_pc", IF_pc_out, 32'h1c000010);
    chk("br_valid", 32'(IF_to_ID_valid), 32'd0);
    chk("br_en", 32'(inst_sram_en), 32'd1);
    chk("br_addr", inst_sram_addr, 32'h1c000100);
    tick(); br_taken = 1'b0; ID_allowin = 1'b0; mid();
    chk("tgt_pc", IF_pc_out, 32'h1c000100);
    chk("tgt_inst", IF_inst_out, 32'h465a0100);
    chk("dlv_010", 32'(dlv_010), 32'd0);

    // Branch while stalled with a full buffer
    tick(); br_taken = 1'b1; br_target = 32'h1c000200; mid();
    chk("sbr_valid", 32'(IF_to_ID_valid), 32'd0);
    chk("sbr_en", 32'(inst_sram_en), 32'd1);
    chk("sbr_addr", inst_sram_addr, 32'h1c000200);
    tick(); br_taken = 1'b0; ID_allowin = 1'b1; mid();
    chk("sbr_pc", IF_pc_out, 32'h1c000200);
    chk("sbr_inst", IF_inst_out, 32'h465a0200);
    chk("dlv_100", 32'(dlv_100), 32'd0);

    // Back-to-back branches: last target wins
    tick(); br_taken = 1'b1; br_target = 32'h1c000300; mid();
    tick(); br_target = 32'h1c000400; mid();
    chk("b2b_pc", IF_pc_out, 32'h1c000300);
    chk("b2b_addr", inst_sram_addr, 32'h1c000400);
    tick(); br_target = 32'hfffffffc; mid();
    chk("b2b_pc2", IF_pc_out, 32'h1c000400);

    // PC wrap
    tick(); br_taken = 1'b0; mid();
    chk("wrap_pc", IF_pc_out, 32'hfffffffc);
    chk("wrap_inst", IF_inst_out, 32'ha5a5fffc);
    chk("wrap_addr", inst_sram_addr, 32'h00000000);

    // Async reset in the middle of a stall with the buffer full
    ID_allowin = 1'b0;
    tick(); tick(); mid();
    chk("pre_rst_inst", IF_inst_out, 32'ha5a5fffc);
    #2 reset = 1'b1; #1;
    chk("arst_valid", 32'(IF_to_ID_valid), 32'd0);
    chk("arst_pc", IF_pc_out, 32'h1bfffffc);
    chk("arst_inst", IF_inst_out, 32'h0);
    chk("arst_en", 32'(inst_sram_en), 32'd0);
    tick(); reset = 1'b0; ID_allowin = 1'b1; mid();
    chk("rr_addr", inst_sram_addr, 32'h1c000000);
    chk("rr_en", 32'(inst_sram_en), 32'd1);
    tick(); mid();
    chk("rr_pc", IF_pc_out, 32'h1c000000);
    chk("rr_inst", IF_inst_out, 32'h465a0000);

`ifdef IF_ADEF_EN
    // Misaligned redirect
    chk("adef_clr", 32'(IF_adef), 32'd0);
    tick(); br_taken = 1'b1; br_target = 32'h1c000102; mid();
    chk("adef_en", 32'(inst_sram_en), 32'd0);
    tick(); br_taken = 1'b0; ID_allowin = 1'b0; mid();
    chk("adef_flag", 32'(IF_adef), 32'd1);
    chk("adef_inst", IF_inst_out, 32'h03400000);
    chk("adef_valid", 32'(IF_to_ID_valid), 32'd1);
    chk("adef_pc", IF_pc_out, 32'h1c000102);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
